// File: rtl/mc_pkg.sv
// Shared encodings for the parametrised multicycle datapath: control codes,
// ALU operations, funct values and instruction field positions.
package mc_pkg;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;
  localparam logic [1:0] AluOpOr    = 2'b11;

  localparam logic [1:0] SrcBReg  = 2'b00;
  localparam logic [1:0] SrcBOne  = 2'b01;
  localparam logic [1:0] SrcBImm  = 2'b10;
  localparam logic [1:0] SrcBImmW = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcHold   = 2'b11;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluNor} alu_ctrl_e;

  typedef enum logic {MemIdle, MemWait} mem_state_e;

  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctSlt = 6'h2A;
  localparam logic [5:0] FunctNor = 6'h27;

  localparam int unsigned FieldW = 6;
  localparam int unsigned OpLsb  = 26;
  localparam int unsigned RsLsb  = 21;
  localparam int unsigned RtLsb  = 16;
  localparam int unsigned RdLsb  = 11;
  localparam int unsigned ImmW   = 16;
  localparam int unsigned JumpW  = 26;

  function automatic logic [31:0] sign_ext16(input logic [ImmW-1:0] imm);
    return {{(32 - ImmW){imm[ImmW-1]}}, imm};
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU control decode (ALUOp plus funct) and 32-bit ALU.
module mc_alu
  import mc_pkg::*;
(
  input  logic [1:0]  alu_op_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  alu_ctrl_e ctrl;

  always_comb begin
    ctrl = AluAdd;
    unique case (alu_op_i)
      AluOpAdd: ctrl = AluAdd;
      AluOpSub: ctrl = AluSub;
      AluOpOr:  ctrl = AluOr;
      AluOpFunct: begin
        case (funct_i)
          FunctAdd: ctrl = AluAdd;
          FunctSub: ctrl = AluSub;
          FunctAnd: ctrl = AluAnd;
          FunctOr:  ctrl = AluOr;
          FunctSlt: ctrl = AluSlt;
          FunctNor: ctrl = AluNor;
          default:  ctrl = AluAdd;
        endcase
      end
    endcase
  end

  always_comb begin
    result_o = a_i + b_i;
    case (ctrl)
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluAnd:  result_o = a_i & b_i;
      AluOr:   result_o = a_i | b_i;
      AluSlt:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      AluNor:  result_o = ~(a_i | b_i);
      default: result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/mc_datapath_p.sv
// Parametrised multicycle datapath: holding registers, register file, ALU muxes
// and a req/ack memory port whose wait states freeze all architectural state.
module mc_datapath_p
  import mc_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              BranchNe,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              IRWrite,
  input  logic              ALUSrcA,
  input  logic              RegWrite,
  input  logic              RegDst,
  input  logic [1:0]        PCSource,
  input  logic [1:0]        ALUSrcB,
  input  logic [1:0]        ALUOp,
  output logic [5:0]        opCode,
  output logic [5:0]        funct,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned RaW = $clog2(NREGS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] rf_q [NREGS];
  logic [31:0] rf_d [NREGS];
  mem_state_e  mem_state_q, mem_state_d;

  logic [RaW-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
  logic [31:0]    alu_a, alu_b, alu_result, wr_data, pc_next;
  logic           alu_zero, pc_en, read_done, rf_we;

  assign opCode = ir_q[OpLsb +: FieldW];
  assign funct  = ir_q[FieldW-1:0];

  // Upper index bits are dropped when NREGS < 32.
  assign rs_idx = ir_q[RsLsb +: RaW];
  assign rt_idx = ir_q[RtLsb +: RaW];
  assign rd_idx = ir_q[RdLsb +: RaW];

  assign mem_req   = (mem_state_q == MemWait) | MemRead | MemWrite;
  assign mem_we    = MemWrite;
  assign stall     = mem_req & ~mem_ack;
  assign read_done = mem_req & mem_ack & ~MemWrite;
  assign mem_addr  = IorD ? aluout_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
  assign mem_wdata = b_q;

  always_comb begin
    alu_a = ALUSrcA ? a_q : pc_q;
    alu_b = b_q;
    unique case (ALUSrcB)
      SrcBReg:           alu_b = b_q;
      SrcBOne:           alu_b = 32'd1;
      SrcBImm, SrcBImmW: alu_b = sign_ext16(ir_q[ImmW-1:0]);
    endcase
  end

  mc_alu u_alu (
    .alu_op_i (ALUOp),
    .funct_i  (ir_q[FieldW-1:0]),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_comb begin
    pc_next = pc_q;
    unique case (PCSource)
      PcSrcAlu:    pc_next = alu_result;
      PcSrcAluOut: pc_next = aluout_q;
      PcSrcJump:   pc_next = {pc_q[31:JumpW], ir_q[JumpW-1:0]};
      PcSrcHold:   pc_next = pc_q;
    endcase
  end

  assign pc_en   = PCWrite | (PCWriteCond & (alu_zero ^ BranchNe));
  assign wr_idx  = RegDst ? rd_idx : rt_idx;
  assign wr_data = MemtoReg ? mdr_q : aluout_q;
  assign rf_we   = RegWrite & ~stall & (wr_idx != '0);

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    rf_d     = rf_q;
    if (!stall) begin
      a_d      = rf_q[rs_idx];
      b_d      = rf_q[rt_idx];
      aluout_d = alu_result;
      if (pc_en) pc_d = pc_next;
      if (rf_we) rf_d[wr_idx] = wr_data;
    end
    // A completed read can only happen in a non-stalled cycle.
    if (read_done) begin
      mdr_d = mem_rdata;
      if (IRWrite) ir_d = mem_rdata;
    end
  end

  always_comb begin
    mem_state_d = mem_state_q;
    unique case (mem_state_q)
      MemIdle: if (mem_req && !mem_ack) mem_state_d = MemWait;
      MemWait: if (mem_ack) mem_state_d = MemIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      mdr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      aluout_q    <= '0;
      rf_q        <= '{default: '0};
      mem_state_q <= MemIdle;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluout_q    <= aluout_d;
      rf_q        <= rf_d;
      mem_state_q <= mem_state_d;
    end
  end

endmodule
